// File: rtl/bridgeio_axil_slave.sv
// bridgeio_axil_slave: AXI4-Lite responder for the bridge I/O register window.
// Four 32-bit control registers at byte offsets 0x00..0x0C, exported on REG_OUT,
// with a one-cycle REG_WR_STB pulse per register update.
// Optional build macro: BRIDGEIO_SLVERR_EN -- unmapped accesses answer SLVERR
// (2'b10) instead of OKAY; data behaviour is the same either way.
module bridgeio_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [4*C_S_AXI_DATA_WIDTH-1:0]   REG_OUT,
    output logic [3:0]                        REG_WR_STB
);

    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int SW    = C_S_AXI_DATA_WIDTH / 8;
    localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [IDX_W-1:0] NUM_REGS = IDX_W'(4);

`ifdef BRIDGEIO_SLVERR_EN
    localparam logic [1:0] UNMAPPED_RESP = 2'b10;
`else
    localparam logic [1:0] UNMAPPED_RESP = 2'b00;
`endif

    typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    w_state_t                w_state;
    r_state_t                r_state;
    logic [3:0][DW-1:0]      regs;
    logic                    aw_w_ready;
    logic                    bvalid;
    logic [1:0]              bresp;
    logic [3:0]              wr_stb;
    logic                    arready;
    logic                    rvalid;
    logic [1:0]              rresp;
    logic [DW-1:0]           rdata;

    logic [IDX_W-1:0]        wr_idx;
    logic [IDX_W-1:0]        rd_idx;
    logic                    wr_mapped;
    logic                    rd_mapped;
    logic                    wr_hs;
    logic                    rd_hs;
    logic                    unused_inputs;

    // Merge the strobed byte lanes of new_val into old_val.
    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_val,
                                                  input logic [DW-1:0] new_val,
                                                  input logic [SW-1:0] strb);
        logic [DW-1:0] res;
        res = old_val;
        for (int k = 0; k < SW; k++) begin
            if (strb[k]) begin
                res[8*k +: 8] = new_val[8*k +: 8];
            end else begin
                res[8*k +: 8] = old_val[8*k +: 8];
            end
        end
        return res;
    endfunction

    // Response code for an access, depending on whether the index is mapped.
    function automatic logic [1:0] resp_for(input logic mapped);
        return mapped ? 2'b00 : UNMAPPED_RESP;
    endfunction

    assign wr_idx    = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign rd_idx    = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign wr_mapped = (wr_idx < NUM_REGS);
    assign rd_mapped = (rd_idx < NUM_REGS);
    // AWREADY/WREADY only rise after both valids were seen, so a handshake needs all three.
    assign wr_hs     = aw_w_ready & S_AXI_AWVALID & S_AXI_WVALID;
    assign rd_hs     = arready & S_AXI_ARVALID;

    // Protection bits and the byte offset inside a word carry no meaning here.
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Write channel: joint AW/W acceptance, byte-lane update, B response and update strobe.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state    <= W_IDLE;
            aw_w_ready <= 1'b0;
            bvalid     <= 1'b0;
            bresp      <= 2'b00;
            wr_stb     <= 4'b0000;
            regs       <= '0;
        end else begin
            wr_stb <= 4'b0000;
            case (w_state)
                W_IDLE: begin
                    if (wr_hs) begin
                        aw_w_ready <= 1'b0;
                        bvalid     <= 1'b1;
                        bresp      <= resp_for(wr_mapped);
                        w_state    <= W_RESP;
                        if (wr_mapped) begin
                            regs[wr_idx[1:0]] <= merge_bytes(regs[wr_idx[1:0]], S_AXI_WDATA, S_AXI_WSTRB);
                            if (S_AXI_WSTRB != '0) begin
                                wr_stb <= 4'b0001 << wr_idx[1:0];
                            end else begin
                                wr_stb <= 4'b0000;
                            end
                        end else begin
                            wr_stb <= 4'b0000;
                        end
                    end else begin
                        // Single-cycle ready pulse once both AW and W are presented.
                        aw_w_ready <= S_AXI_AWVALID & S_AXI_WVALID & ~aw_w_ready;
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        bvalid     <= 1'b0;
                        w_state    <= W_IDLE;
                        // Back-to-back: a waiting write is accepted in the very next cycle.
                        aw_w_ready <= S_AXI_AWVALID & S_AXI_WVALID;
                    end else begin
                        aw_w_ready <= 1'b0;
                    end
                end
                default: begin
                    w_state    <= W_IDLE;
                    aw_w_ready <= 1'b0;
                    bvalid     <= 1'b0;
                end
            endcase
        end
    end

    // Read channel: single-cycle ARREADY, RDATA latched at the handshake, held until RREADY.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rresp   <= 2'b00;
            rdata   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (rd_hs) begin
                        arready <= 1'b0;
                        rvalid  <= 1'b1;
                        rresp   <= resp_for(rd_mapped);
                        // Samples pre-write contents when a write lands on the same edge.
                        rdata   <= rd_mapped ? regs[rd_idx[1:0]] : '0;
                        r_state <= R_DATA;
                    end else begin
                        arready <= S_AXI_ARVALID & ~arready;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        rvalid  <= 1'b0;
                        r_state <= R_IDLE;
                        // Back-to-back: a waiting read is accepted in the very next cycle.
                        arready <= S_AXI_ARVALID;
                    end else begin
                        arready <= 1'b0;
                    end
                end
                default: begin
                    r_state <= R_IDLE;
                    arready <= 1'b0;
                    rvalid  <= 1'b0;
                end
            endcase
        end
    end

    assign S_AXI_AWREADY = aw_w_ready;
    assign S_AXI_WREADY  = aw_w_ready;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = bresp;
    assign S_AXI_ARREADY = arready;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RRESP   = rresp;
    assign S_AXI_RDATA   = rdata;
    assign REG_OUT       = regs;
    assign REG_WR_STB    = wr_stb;

endmodule
